// File: rtl/psum_gbf_drain_if.sv
// rtl/psum_gbf_drain_if.sv - adder-side and drain-side bus bundle for psum_gbf_drain
//
// Purpose: groups the adder read/write/init traffic, the bank control and the
// drain stream of the double-buffered partial-sum global buffer.
//
// Signals:
//   w_en/w_addr/w_data     write into active bank        (master -> slave)
//   w_num                  active bank select             (master -> slave)
//   r_en/r_addr            read from active bank          (master -> slave)
//   r_data                 registered read data           (slave -> master)
//   init_en/init_addr      zero-write into active bank    (master -> slave)
//   flush                  mark active bank complete      (master -> slave)
//   drain_valid/ready      drain stream handshake
//   drain_data/addr/bank   drain stream payload           (slave -> master)
//   drain_done             bank fully drained pulse       (slave -> master)
//   busy/overrun           status                         (slave -> master)
interface psum_gbf_drain_if #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5
);
  logic                     w_en;
  logic [ADDR_BITWIDTH-1:0] w_addr;
  logic [DATA_BITWIDTH-1:0] w_data;
  logic                     w_num;
  logic                     r_en;
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [DATA_BITWIDTH-1:0] r_data;
  logic                     init_en;
  logic [ADDR_BITWIDTH-1:0] init_addr;
  logic                     flush;
  logic                     drain_valid;
  logic                     drain_ready;
  logic [DATA_BITWIDTH-1:0] drain_data;
  logic [ADDR_BITWIDTH-1:0] drain_addr;
  logic                     drain_bank;
  logic                     drain_done;
  logic                     busy;
  logic                     overrun;

  modport slave (
    input  w_en, w_addr, w_data, w_num, r_en, r_addr, init_en, init_addr,
           flush, drain_ready,
    output r_data, drain_valid, drain_data, drain_addr, drain_bank,
           drain_done, busy, overrun
  );

  modport master (
    output w_en, w_addr, w_data, w_num, r_en, r_addr, init_en, init_addr,
           flush, drain_ready,
    input  r_data, drain_valid, drain_data, drain_addr, drain_bank,
           drain_done, busy, overrun
  );
endinterface

// File: rtl/psum_gbf_drain.sv
// rtl/psum_gbf_drain.sv - double-buffered psum global buffer with bank drain stream
//
// Purpose: two register-array banks. The adder stage reads, writes and
// zero-inits the active bank (w_num). A bank that is switched away from, or
// flushed, becomes pending and is streamed out word by word on the drain port.
// Writes aimed at a pending/draining bank are dropped and raise sticky overrun.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    psum_gbf_drain_if.slave (adder traffic, bank control, drain stream, status)
//
// Build option: define PSUM_GBF_RELU_EN to zero every negative LANE_BITWIDTH
// lane of drained words (adder-side r_data is never affected).
module psum_gbf_drain #(
  parameter int DATA_BITWIDTH = 512,
  parameter int LANE_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32
) (
  input  logic           clk,
  input  logic           reset,
  psum_gbf_drain_if.slave bus
);

`ifdef PSUM_GBF_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DATA_BITWIDTH-1:0] r_mem0 [DEPTH];
  logic [DATA_BITWIDTH-1:0] r_mem1 [DEPTH];

  logic                     r_w_num_q;
  logic [1:0]               r_pend;
  logic [ADDR_BITWIDTH-1:0] r_cnt;
  logic                     r_drain_bank;
  logic [DATA_BITWIDTH-1:0] r_drain_data;
  logic [ADDR_BITWIDTH-1:0] r_drain_addr;
  logic                     r_drain_done;
  logic [DATA_BITWIDTH-1:0] r_rd_data;
  logic                     r_overrun;

  logic                     w_blocked;
  logic                     w_collide;
  logic                     w_wr_ok;
  logic                     w_init_ok;
  logic [1:0]               w_pend_set;
  logic [1:0]               w_pend_clr;
  logic                     w_load;
  logic                     w_fetch;
  logic                     w_accept;
  logic                     w_last;
  logic [DATA_BITWIDTH-1:0] w_raw;
  logic [DATA_BITWIDTH-1:0] w_fetch_data;

  // Clamp negative signed lanes to zero.
  function automatic logic [DATA_BITWIDTH-1:0] relu_word(input logic [DATA_BITWIDTH-1:0] word);
    logic [DATA_BITWIDTH-1:0] res;
    res = word;
    for (int i = 0; i < DATA_BITWIDTH / LANE_BITWIDTH; i++) begin
      if (word[i*LANE_BITWIDTH + LANE_BITWIDTH - 1]) begin
        res[i*LANE_BITWIDTH +: LANE_BITWIDTH] = '0;
      end
    end
    return res;
  endfunction

  // A bank is off-limits to the adder from the edge it turns pending until
  // its drain completes (pend stays set for the whole drain).
  assign w_blocked = r_pend[bus.w_num] | ((r_state != S_IDLE) & (r_drain_bank == bus.w_num));
  assign w_collide = (bus.w_en | bus.init_en) & w_blocked;
  assign w_wr_ok   = bus.w_en & ~w_blocked;
  assign w_init_ok = bus.init_en & ~w_blocked;

  always_comb begin
    w_pend_set = 2'b00;
    if (bus.w_num != r_w_num_q) begin
      w_pend_set[r_w_num_q] = 1'b1;
    end
    if (bus.flush) begin
      w_pend_set[bus.w_num] = 1'b1;
    end
  end

  assign w_pend_clr   = w_last ? {r_drain_bank, ~r_drain_bank} : 2'b00;
  assign w_raw        = r_drain_bank ? r_mem1[r_cnt] : r_mem0[r_cnt];
  assign w_fetch_data = RELU ? relu_word(w_raw) : w_raw;

  // Memory banks are not reset. w_en is assigned last so it wins over
  // init_en on an address clash; distinct addresses both land.
  always_ff @(posedge clk) begin
    if (w_init_ok && !bus.w_num) r_mem0[bus.init_addr] <= '0;
    if (w_init_ok &&  bus.w_num) r_mem1[bus.init_addr] <= '0;
    if (w_wr_ok   && !bus.w_num) r_mem0[bus.w_addr]    <= bus.w_data;
    if (w_wr_ok   &&  bus.w_num) r_mem1[bus.w_addr]    <= bus.w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fetch     = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_load      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (bus.drain_ready) begin
          w_accept = 1'b1;
          if (r_cnt == LAST_ADDR) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w_num_q    <= 1'b0;
      r_pend       <= 2'b00;
      r_cnt        <= '0;
      r_drain_bank <= 1'b0;
      r_drain_data <= '0;
      r_drain_addr <= '0;
      r_drain_done <= 1'b0;
      r_rd_data    <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_w_num_q    <= bus.w_num;
      // Re-pending an already pending bank is harmless; completion clear wins.
      r_pend       <= (r_pend | w_pend_set) & ~w_pend_clr;
      r_overrun    <= r_overrun | w_collide;
      r_drain_done <= w_last;
      if (bus.r_en) begin
        r_rd_data <= bus.w_num ? r_mem1[bus.r_addr] : r_mem0[bus.r_addr];
      end
      if (w_load) begin
        r_cnt        <= '0;
        r_drain_bank <= ~r_pend[0];
      end
      if (w_fetch) begin
        r_drain_data <= w_fetch_data;
        r_drain_addr <= r_cnt;
      end
      if (w_accept && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.r_data      = r_rd_data;
  assign bus.drain_valid = (r_state == S_SEND);
  assign bus.drain_data  = r_drain_data;
  assign bus.drain_addr  = r_drain_addr;
  assign bus.drain_bank  = r_drain_bank;
  assign bus.drain_done  = r_drain_done;
  assign bus.busy        = (r_state != S_IDLE) | (|r_pend);
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_psum_gbf_drain.sv
// tb/tb_psum_gbf_drain.sv - self-checking bench for psum_gbf_drain
`timescale 1ns/1ps
module tb_psum_gbf_drain;
  localparam int D = 512;
  localparam int L = 16;
  localparam int A = 5;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  psum_gbf_drain_if #(.DATA_BITWIDTH(D), .ADDR_BITWIDTH(A)) bus();

  psum_gbf_drain #(
    .DATA_BITWIDTH(D),
    .LANE_BITWIDTH(L),
    .ADDR_BITWIDTH(A),
    .DEPTH(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [D-1:0] model [2][N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] rand_word();
    logic [D-1:0] v;
    for (int k = 0; k < D / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // What the drain port should carry for a stored word.
  function automatic logic [D-1:0] drained(input logic [D-1:0] w);
    logic [D-1:0] r;
    r = w;
`ifdef PSUM_GBF_RELU_EN
    for (int i = 0; i < D / L; i++) begin
      if ($signed(w[i*L +: L]) < 0) r[i*L +: L] = '0;
    end
`endif
    return r;
  endfunction

  task automatic wr(input int addr, input logic [D-1:0] data);
    bus.w_en   = 1'b1;
    bus.w_addr = A'(addr);
    bus.w_data = data;
    tick();
    bus.w_en   = 1'b0;
  endtask

  // Consumes one whole bank from the drain port. The first tick is the edge
  // that makes the bank pending; exp_cycles < 0 skips the latency check.
  task automatic drain_check(input int bank, input int stall_at, input int stall_len, input int exp_cycles);
    int idx;
    int t;
    int stalled;
    bit done;
    logic [D-1:0] prev_data;
    logic [A-1:0] prev_addr;
    idx = 0; t = 0; stalled = 0; done = 1'b0;
    prev_data = '0; prev_addr = '0;
    bus.drain_ready = 1'b1;
    while (!done && t < 400) begin
      tick();
      t++;
      if (t == 1) bus.flush = 1'b0;
      if (bus.drain_done) begin
        done = 1'b1;
        chk("drain_count", D'(idx), D'(N));
        if (exp_cycles >= 0) chk("drain_latency", D'(t - 1), D'(exp_cycles));
      end else if (bus.drain_valid) begin
        chk("drain_addr", D'(bus.drain_addr), D'(idx));
        chk("drain_bank", D'(bus.drain_bank), D'(bank));
        chk("drain_data", bus.drain_data, drained(model[bank][idx]));
        if (idx == stall_at && stalled > 0) begin
          chk("stall_data_stable", bus.drain_data, prev_data);
          chk("stall_addr_stable", D'(bus.drain_addr), D'(prev_addr));
        end
        prev_data = bus.drain_data;
        prev_addr = bus.drain_addr;
        if (idx == stall_at && stalled < stall_len) begin
          bus.drain_ready = 1'b0;
          stalled++;
        end else begin
          bus.drain_ready = 1'b1;
          idx++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected_beats=%0d", idx, N);
    end else begin
      tick();
      chk("drain_done_pulse", D'(bus.drain_done), D'(0));
    end
    bus.drain_ready = 1'b0;
  endtask

  initial begin
    logic [D-1:0] old3;

    // Reset with random inputs.
    for (int c = 0; c < 3; c++) begin
      bus.w_en = 1'($urandom); bus.w_addr = A'($urandom); bus.w_data = rand_word();
      bus.w_num = 1'($urandom); bus.r_en = 1'($urandom); bus.r_addr = A'($urandom);
      bus.init_en = 1'($urandom); bus.init_addr = A'($urandom);
      bus.flush = 1'($urandom); bus.drain_ready = 1'($urandom);
      tick();
    end
    chk("rst_r_data", bus.r_data, '0);
    chk("rst_drain_valid", D'(bus.drain_valid), '0);
    chk("rst_drain_data", bus.drain_data, '0);
    chk("rst_drain_addr", D'(bus.drain_addr), '0);
    chk("rst_drain_bank", D'(bus.drain_bank), '0);
    chk("rst_drain_done", D'(bus.drain_done), '0);
    chk("rst_busy", D'(bus.busy), '0);
    chk("rst_overrun", D'(bus.overrun), '0);
    bus.w_en = 0; bus.w_num = 0; bus.r_en = 0; bus.init_en = 0;
    bus.flush = 0; bus.drain_ready = 0; bus.w_addr = '0; bus.r_addr = '0;
    bus.init_addr = '0; bus.w_data = '0;
    tick();
    reset = 1'b1;
    tick();

    // Read-first and read latency on bank 0 address 5.
    wr(5, D'(32'hA));
    bus.w_en = 1; bus.w_addr = 5; bus.w_data = D'(32'hB);
    bus.r_en = 1; bus.r_addr = 5;
    tick();
    bus.w_en = 0; bus.r_en = 0;
    chk("read_first_old", bus.r_data, D'(32'hA));
    bus.r_en = 1;
    tick();
    bus.r_en = 0;
    chk("read_new", bus.r_data, D'(32'hB));
    tick();
    chk("read_hold", bus.r_data, D'(32'hB));
    bus.init_en = 1; bus.init_addr = 5;
    tick();
    bus.init_en = 0; bus.r_en = 1;
    tick();
    bus.r_en = 0;
    chk("read_after_init", bus.r_data, '0);

    // Fill bank 0 with the byte-replicated address pattern, switch banks.
    for (int a = 0; a < N; a++) begin
      logic [7:0] b;
      b = 8'(a);
      model[0][a] = {64{b}};
      wr(a, model[0][a]);
    end
    chk("busy_before_switch", D'(bus.busy), '0);
    bus.w_num = 1;
    drain_check(0, -1, 0, 2 * N + 1);
    chk("no_overrun_clean", D'(bus.overrun), '0);
    chk("idle_after_drain", D'(bus.busy), '0);

    // Random fill of bank 1, flush, drain with 7 cycles of backpressure.
    for (int a = 0; a < N; a++) begin
      model[1][a] = rand_word();
      wr(a, model[1][a]);
    end
    bus.flush = 1;
    drain_check(1, 10, 7, 2 * N + 1 + 7);

    // Switch back to bank 0: bank 1 is pending again and drains unchanged.
    bus.w_num = 0;
    drain_check(1, -1, 0, 2 * N + 1);

    // Overrun: refill bank 0, flush, toggle 0->1->0, then write address 3.
    for (int a = 0; a < N; a++) begin
      model[0][a] = rand_word();
      wr(a, model[0][a]);
    end
    old3 = model[0][3];
    bus.flush = 1;
    fork
      drain_check(0, -1, 0, 2 * N + 1);
      begin
        tick();
        bus.flush = 0;
        bus.w_num = 1;
        tick();
        bus.w_num = 0;
        tick();
        bus.w_en = 1; bus.w_addr = 3; bus.w_data = ~old3;
        tick();
        bus.w_en = 0;
      end
    join
    chk("overrun_set", D'(bus.overrun), D'(1));
    // The 1->0 toggle queued bank 1 behind bank 0.
    drain_check(1, -1, 0, -1);
    chk("overrun_sticky", D'(bus.overrun), D'(1));
    bus.r_en = 1; bus.r_addr = 3;
    tick();
    bus.r_en = 0;
    chk("dropped_write_read", bus.r_data, old3);

    // Reset mid-drain aborts and does not re-queue.
    bus.flush = 1;
    tick();
    bus.flush = 0;
    for (int c = 0; c < 5; c++) tick();
    chk("mid_drain_busy", D'(bus.busy), D'(1));
    reset = 1'b0;
    tick();
    chk("abort_valid", D'(bus.drain_valid), '0);
    chk("abort_busy", D'(bus.busy), '0);
    chk("abort_overrun", D'(bus.overrun), '0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("no_requeue_busy", D'(bus.busy), '0);
    chk("no_requeue_valid", D'(bus.drain_valid), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_gbf_drain.md
# psum_gbf_drain

Double-buffered partial-sum global buffer sitting directly downstream of the PE array + spatial-unrolling adder stage. It services that stage's read / accumulate-write / zero-init traffic on the active bank (`w_num`). When the stage flips to the other bank, or `flush` is pulsed, it streams the completed bank out word by word over a valid/ready drain port toward the off-chip write-back path.

## Interface
- `DATA_BITWIDTH`, 512: width of one psum_gbf word; must equal the adder's `PSUM_GBF_DATA_BITWIDTH`.
- `LANE_BITWIDTH`, 16: signed psum lane width; `DATA_BITWIDTH` must be a multiple of it.
- `ADDR_BITWIDTH`, 5: word address width.
- `DEPTH`, 32: words per bank; equals 2^`ADDR_BITWIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `w_en` in 1, `w_addr` in `ADDR_BITWIDTH`, `w_data` in `DATA_BITWIDTH`: accumulate write into bank `w_num`.
- `w_num` in 1: active bank (0 = bank1, 1 = bank2).
- `r_en` in 1, `r_addr` in `ADDR_BITWIDTH`: read from bank `w_num`.
- `r_data` out `DATA_BITWIDTH`: read data.
- `init_en` in 1, `init_addr` in `ADDR_BITWIDTH`: write zero into bank `w_num`.
- `flush` in 1: pulse; marks bank `w_num` complete (end of layer).
- `drain_valid` out 1, `drain_ready` in 1, `drain_data` out `DATA_BITWIDTH`, `drain_addr` out `ADDR_BITWIDTH`, `drain_bank` out 1: drain stream.
- `drain_done` out 1: one-cycle pulse after the last word of a bank is accepted.
- `busy` out 1: drain FSM not IDLE or a bank pending.
- `overrun` out 1: sticky error flag.

## Operation
- Two reg-array banks. Memory contents are not reset.
- Each bank has one write path and two read muxes (adder side, drain side).
- Write priority on bank `w_num`, same cycle: `w_en` over `init_en`. Different addresses: both writes take effect.
- Pending detection:
  - `w_num` is registered (`w_num_q`, reset 0).
  - A change of `w_num` sets `pend[w_num_q]`.
  - `flush` sets `pend[w_num]`.
- Drain FSM:
  - IDLE: if any `pend` bit is set → FETCH, selecting bank1 first when both are set. Load `cnt = 0` and `drain_bank`.
  - FETCH: register `mem[drain_bank][cnt]` into `drain_data`, set `drain_addr = cnt` → SEND.
  - SEND: `drain_valid = 1`. On `drain_ready`:
    - if `cnt == DEPTH-1`: clear `pend[drain_bank]`, pulse `drain_done` → IDLE.
    - else: `cnt++` → FETCH.
- Collision: any `w_en` or `init_en` while `w_num` equals the bank that is pending or draining:
  - the write is dropped;
  - `overrun` is set. It clears only on reset.
- A `w_num` toggle or `flush` for a bank that is already pending is a no-op; `overrun` is not set.
- Adder reads are never blocked. A read of the draining bank returns its stored contents.

## Timing
- Reset values: `r_data = 0`, `drain_valid = 0`, `drain_data = 0`, `drain_addr = 0`, `drain_bank = 0`, `drain_done = 0`, `busy = 0`, `overrun = 0`. FSM goes to IDLE; `pend` and `cnt` cleared.
- Reset asserted mid-drain aborts the drain immediately. The partially drained bank is not re-queued.
- `r_data`:
  - registered, valid the cycle after `r_en`; holds its value when `r_en = 0`;
  - read-first: a same-cycle write to the same address returns the old word.
- Pending is set at the edge where the `w_num` change or `flush` is sampled. FETCH starts at the earliest 2 cycles later (IDLE → FETCH → SEND).
- Drain throughput: one word per 2 cycles with `drain_ready` held high. A bank drains in 2·`DEPTH`+1 cycles from pend to `drain_done`.
- `drain_data`, `drain_addr` and `drain_bank` stay stable while `drain_valid && !drain_ready`.
- `drain_done` is asserted in the cycle after the final handshake, concurrent with the return to IDLE.

## Configuration
- `PSUM_GBF_RELU_EN` defined: in FETCH, every signed `LANE_BITWIDTH` lane of the drained word with its MSB set is replaced by 0. This applies to drain output only; `r_data` is unaffected.
- `PSUM_GBF_RELU_EN` undefined: drained words are bit-exact copies of memory.

## Test plan
- Reset check: assert `reset = 0` for 3 cycles with random inputs → all outputs 0; `busy = 0`.
- Bank 0 fill and drain:
  - stimulus: with `w_num = 0`, write `w_data = addr·0x0101…` to all 32 addresses, then set `w_num = 1`, `drain_ready = 1`;
  - response: 32 beats on bank 0 with `drain_addr` 0..31 and matching data; `drain_done` pulses exactly 65 cycles after the pend edge.
- Read-first and latency:
  - stimulus: `w_en` plus `r_en` to address 5, where old = 0xA and new = 0xB;
  - response: `r_data = 0xA` next cycle; a read one cycle later gives 0xB. `init_en` to address 5 then a read gives 0.
- Backpressure:
  - stimulus: during a drain, hold `drain_ready = 0` for 7 cycles in SEND;
  - response: `drain_valid`, `drain_data` and `drain_addr` stay stable; after release the sequence continues with no loss or duplication.
- Overrun:
  - stimulus: toggle `w_num` 0→1→0 while bank 0 is still draining, then `w_en` to address 3;
  - response: the write is dropped (drained word 3 keeps its old value) and `overrun = 1` until reset.
- ReLU build (`PSUM_GBF_RELU_EN`): a lane value of 0xFFF0 drains as 0x0000 and 0x0010 drains as 0x0010, while `r_data` still returns 0xFFF0.
